// File: rtl/layer_phase_sequencer.sv
// layer_phase_sequencer
//   Sequences one CNN layer as a series of tiles. Each tile runs a read
//   phase (IFM/weights), a compute phase on the PE array and, depending on
//   the layer type, an OFM write phase. Fully-connected layers accumulate
//   across all tiles and write only once, after the last tile.
//
// Ports
//   clk, rst           : clock and synchronous active-high reset
//   layer_type [1:0]   : NONE=00, CONVOLUTION=01, POOLING=10, FULLY=11
//   layer_start        : one-cycle request to run a layer (IDLE only)
//   num_tiles [TILE_W] : number of tiles in the layer
//   pause              : suspend request, sampled on every entry to READ
//   rd_req / rd_done   : read handshake
//   comp_en / comp_done: compute handshake
//   wr_req / wr_done   : write handshake
//   tile_idx [TILE_W]  : current tile number
//   cur_layer [1:0]    : layer type latched for the running layer
//   phase [3:0]        : current state encoding
//   busy               : high in every state except IDLE
//   ofm_valid          : one-cycle layer-complete pulse
module layer_phase_sequencer #(
  parameter int TILE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        layer_type,
  input  logic              layer_start,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic              pause,
  output logic              rd_req,
  input  logic              rd_done,
  output logic              comp_en,
  input  logic              comp_done,
  output logic              wr_req,
  input  logic              wr_done,
  output logic [TILE_W-1:0] tile_idx,
  output logic [1:0]        cur_layer,
  output logic [3:0]        phase,
  output logic              busy,
  output logic              ofm_valid
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0000,
    S_READ    = 4'b0100,
    S_COMP    = 4'b0101,
    S_WRITE   = 4'b0110,
    S_INIT    = 4'b0111,
    S_SUSPEND = 4'b1000,
    S_FINISH  = 4'b1001
  } state_t;

  localparam logic [1:0]        LT_NONE  = 2'b00;
  localparam logic [1:0]        LT_FULLY = 2'b11;
  localparam logic [TILE_W-1:0] TILE_ONE = {{(TILE_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
  logic [TILE_W-1:0] total_q, total_d;
  logic [1:0]        cur_layer_q, cur_layer_d;
  logic              last_tile;

  // Only meaningful once total_q >= 1, i.e. after INIT decided to run
  // tiles; tile_idx therefore never passes total-1 and never wraps.
  assign last_tile = (tile_idx_q == (total_q - TILE_ONE));

  always_comb begin
    state_d     = state_q;
    tile_idx_d  = tile_idx_q;
    total_d     = total_q;
    cur_layer_d = cur_layer_q;

    unique case (state_q)
      S_IDLE: begin
        if (layer_start && (layer_type != LT_NONE)) begin
          state_d = S_INIT;
        end
      end

      S_INIT: begin
        // Capture the layer parameters at the end of INIT; later changes
        // on the inputs cannot disturb the running layer.
        cur_layer_d = layer_type;
        total_d     = num_tiles;
        tile_idx_d  = '0;
        if (num_tiles == '0) begin
          state_d = S_FINISH;
        end else if (pause) begin
          state_d = S_SUSPEND;
        end else begin
          state_d = S_READ;
        end
      end

      S_READ: begin
        if (rd_done) begin
          state_d = S_COMP;
        end
      end

      S_COMP: begin
        if (comp_done) begin
          if ((cur_layer_q == LT_FULLY) && !last_tile) begin
            // Accumulate into the PE array: no write between FC tiles.
            tile_idx_d = tile_idx_q + TILE_ONE;
            state_d    = pause ? S_SUSPEND : S_READ;
          end else begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        if (wr_done) begin
          if (last_tile) begin
            state_d = S_FINISH;
          end else begin
            tile_idx_d = tile_idx_q + TILE_ONE;
            state_d    = pause ? S_SUSPEND : S_READ;
          end
        end
      end

      S_SUSPEND: begin
        if (!pause) begin
          state_d = S_READ;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tile_idx_q  <= '0;
      total_q     <= '0;
      cur_layer_q <= LT_NONE;
    end else begin
      state_q     <= state_d;
      tile_idx_q  <= tile_idx_d;
      total_q     <= total_d;
      cur_layer_q <= cur_layer_d;
    end
  end

  // Moore outputs: decoded from the registered state only.
  assign rd_req    = (state_q == S_READ);
  assign comp_en   = (state_q == S_COMP);
  assign wr_req    = (state_q == S_WRITE);
  assign ofm_valid = (state_q == S_FINISH);
  assign busy      = (state_q != S_IDLE);
  assign phase     = state_q;
  assign tile_idx  = tile_idx_q;
  assign cur_layer = cur_layer_q;

endmodule

// File: tb/tb_layer_phase_sequencer.sv
module tb_layer_phase_sequencer;

  localparam int TILE_W = 8;

  localparam logic [3:0] P_IDLE  = 4'b0000;
  localparam logic [3:0] P_READ  = 4'b0100;
  localparam logic [3:0] P_COMP  = 4'b0101;
  localparam logic [3:0] P_WRITE = 4'b0110;
  localparam logic [3:0] P_INIT  = 4'b0111;
  localparam logic [3:0] P_SUSP  = 4'b1000;
  localparam logic [3:0] P_FIN   = 4'b1001;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        layer_type = 2'b00;
  logic              layer_start = 1'b0;
  logic [TILE_W-1:0] num_tiles = '0;
  logic              pause = 1'b0;
  logic              rd_req, comp_en, wr_req;
  logic              rd_done = 1'b0, comp_done = 1'b0, wr_done = 1'b0;
  logic [TILE_W-1:0] tile_idx;
  logic [1:0]        cur_layer;
  logic [3:0]        phase;
  logic              busy, ofm_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] ph;
    int         tile;
  } step_t;

  layer_phase_sequencer #(.TILE_W(TILE_W)) dut (
    .clk(clk), .rst(rst), .layer_type(layer_type), .layer_start(layer_start),
    .num_tiles(num_tiles), .pause(pause),
    .rd_req(rd_req), .rd_done(rd_done),
    .comp_en(comp_en), .comp_done(comp_done),
    .wr_req(wr_req), .wr_done(wr_done),
    .tile_idx(tile_idx), .cur_layer(cur_layer), .phase(phase),
    .busy(busy), .ofm_valid(ofm_valid)
  );

  always #5 clk = ~clk;

  // Reset at power-up: everything idle and cleared.
  task automatic test_reset();
    rst = 1'b1;
    layer_start = 1'b1; layer_type = 2'b01; num_tiles = 8'd4;
    rd_done = 1'b1; comp_done = 1'b1; wr_done = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (phase !== P_IDLE || busy !== 1'b0 || tile_idx !== '0 || cur_layer !== 2'b00 ||
        rd_req !== 1'b0 || comp_en !== 1'b0 || wr_req !== 1'b0 || ofm_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset: phase=%b busy=%b tile=%0d cur=%b rd=%b comp=%b wr=%b ofm=%b required phase=0000 all others 0",
               phase, busy, tile_idx, cur_layer, rd_req, comp_en, wr_req, ofm_valid);
    end
    rst = 1'b0; layer_start = 1'b0;
    rd_done = 1'b0; comp_done = 1'b0; wr_done = 1'b0;
    @(negedge clk);
    $display("reset: phase=%b busy=%b", phase, busy);
  endtask

  // Ignored inputs in IDLE: start with type NONE and stray done pulses.
  task automatic test_ignored_idle();
    layer_type = 2'b00; num_tiles = 8'd3; layer_start = 1'b1;
    rd_done = 1'b1; comp_done = 1'b1; wr_done = 1'b1;
    @(negedge clk);
    layer_start = 1'b0; rd_done = 1'b0; comp_done = 1'b0; wr_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (phase !== P_IDLE || busy !== 1'b0 || tile_idx !== '0 || ofm_valid !== 1'b0) begin
        errors++;
        $display("FAIL ignored_idle[%0d]: phase=%b busy=%b tile=%0d ofm=%b required phase=0000 busy=0 tile=0 ofm=0",
                 k, phase, busy, tile_idx, ofm_valid);
      end
      @(negedge clk);
    end
    $display("ignored_idle: phase=%b", phase);
  endtask

  // Runs one layer against a step-list model of the expected phases.
  //   lat   : done latency in cycles after the request (-1 = random 0..3)
  //   pmode : 0 = never pause, 1 = random pauses, 2 = pause once before tile 1
  //   stray : inject non-matching done pulses and layer_start while busy
  task automatic run_layer(input string name, input logic [1:0] lt, input int n,
                           input int lat, input int pmode, input bit stray);
    step_t      steps[$];
    step_t      nxt;
    logic [3:0] eph;
    int         etile, idx, wait_left, susp_left, cyc, ofm_cnt;
    bit         fin, p, paused_once;

    for (int t = 0; t < n; t++) begin
      steps.push_back('{P_READ, t});
      steps.push_back('{P_COMP, t});
      if (lt != 2'b11 || t == n - 1) steps.push_back('{P_WRITE, t});
    end
    steps.push_back('{P_FIN, (n == 0) ? 0 : n - 1});

    layer_type = lt; num_tiles = n[TILE_W-1:0]; layer_start = 1'b1; pause = 1'b0;
    @(negedge clk);
    layer_start = 1'b0;

    eph = P_INIT; etile = 0; idx = 0; wait_left = 0; susp_left = 0;
    cyc = 0; ofm_cnt = 0; fin = 1'b0; paused_once = 1'b0;

    while (!fin) begin
      checks++;
      if (phase !== eph) begin
        errors++;
        $display("FAIL %s phase (cycle %0d): got %b expected %b", name, cyc, phase, eph);
      end
      if (eph != P_INIT && eph != P_IDLE) begin
        checks++;
        if (tile_idx !== etile[TILE_W-1:0]) begin
          errors++;
          $display("FAIL %s tile_idx (cycle %0d): got %0d expected %0d", name, cyc, tile_idx, etile);
        end
      end
      if (eph != P_INIT) begin
        checks++;
        if (cur_layer !== lt) begin
          errors++;
          $display("FAIL %s cur_layer (cycle %0d): got %b expected %b", name, cyc, cur_layer, lt);
        end
      end
      checks++;
      if (rd_req !== (eph == P_READ) || comp_en !== (eph == P_COMP) ||
          wr_req !== (eph == P_WRITE) || ofm_valid !== (eph == P_FIN) ||
          busy !== (eph != P_IDLE)) begin
        errors++;
        $display("FAIL %s outputs (cycle %0d): rd=%b comp=%b wr=%b ofm=%b busy=%b expected for phase %b",
                 name, cyc, rd_req, comp_en, wr_req, ofm_valid, busy, eph);
      end
      if (ofm_valid === 1'b1) ofm_cnt++;

      if (eph == P_IDLE) begin
        fin = 1'b1;
      end else begin
        // Parameters may change freely once the layer has been latched.
        if (eph != P_INIT) begin
          layer_type = 2'($urandom);
          num_tiles  = TILE_W'($urandom);
        end
        case (eph)
          P_INIT, P_READ, P_COMP, P_WRITE: begin
            if (eph != P_INIT && wait_left > 0) begin
              wait_left--;
              if (stray && $urandom_range(0, 2) == 0) begin
                rd_done   = (eph != P_READ);
                comp_done = (eph != P_COMP);
                wr_done   = (eph != P_WRITE);
              end
              if (stray && $urandom_range(0, 3) == 0) layer_start = 1'b1;
            end else begin
              rd_done   = (eph == P_READ);
              comp_done = (eph == P_COMP);
              wr_done   = (eph == P_WRITE);
              nxt = steps[idx];
              p = 1'b0;
              if (nxt.ph == P_READ) begin
                if (pmode == 1) p = ($urandom_range(0, 2) == 0);
                if (pmode == 2) p = (nxt.tile == 1 && !paused_once);
              end
              pause = p;
              if (p) begin
                paused_once = 1'b1;
                eph = P_SUSP; etile = nxt.tile;
                susp_left = (pmode == 2) ? 2 : $urandom_range(0, 3);
              end else begin
                eph = nxt.ph; etile = nxt.tile; idx++;
                wait_left = (lat >= 0) ? lat : $urandom_range(0, 3);
              end
            end
          end
          P_SUSP: begin
            if (susp_left > 0) begin
              susp_left--;
              pause = 1'b1;
            end else begin
              pause = 1'b0;
              eph = steps[idx].ph; etile = steps[idx].tile; idx++;
              wait_left = (lat >= 0) ? lat : $urandom_range(0, 3);
            end
          end
          P_FIN: begin
            eph = P_IDLE;
          end
          default: begin
            eph = P_IDLE;
          end
        endcase
        @(negedge clk);
        rd_done = 1'b0; comp_done = 1'b0; wr_done = 1'b0;
        layer_start = 1'b0; pause = 1'b0;
        if (eph == P_SUSP) pause = 1'b1;
        cyc++;
        if (cyc > 20000) begin
          checks++; errors++;
          $display("FAIL %s timeout: got no return to IDLE after %0d cycles, expected completion", name, cyc);
          fin = 1'b1;
        end
      end
    end
    checks++;
    if (ofm_cnt != 1) begin
      errors++;
      $display("FAIL %s ofm_count: got %0d pulses expected 1", name, ofm_cnt);
    end
    $display("%s: type=%b tiles=%0d cycles=%0d ofm_pulses=%0d", name, lt, n, cyc, ofm_cnt);
  endtask

  // Reset while computing tile 1 of a CONV layer aborts with no ofm_valid.
  task automatic test_reset_mid_layer();
    layer_type = 2'b01; num_tiles = 8'd3; layer_start = 1'b1;
    @(negedge clk); layer_start = 1'b0;             // INIT
    @(negedge clk); rd_done = 1'b1;                 // READ t0
    @(negedge clk); rd_done = 1'b0; comp_done = 1'b1; // COMP t0
    @(negedge clk); comp_done = 1'b0; wr_done = 1'b1; // WRITE t0
    @(negedge clk); wr_done = 1'b0; rd_done = 1'b1;   // READ t1
    @(negedge clk); rd_done = 1'b0;                 // COMP t1
    checks++;
    if (phase !== P_COMP || tile_idx !== 8'd1) begin
      errors++;
      $display("FAIL reset_mid setup: phase=%b tile=%0d required 0101 tile 1", phase, tile_idx);
    end
    rst = 1'b1; comp_done = 1'b1; layer_start = 1'b1;
    @(negedge clk);
    rst = 1'b0; comp_done = 1'b0; layer_start = 1'b0;
    checks++;
    if (phase !== P_IDLE || busy !== 1'b0 || rd_req !== 1'b0 || comp_en !== 1'b0 ||
        wr_req !== 1'b0 || ofm_valid !== 1'b0 || tile_idx !== '0 || cur_layer !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid: phase=%b busy=%b rd=%b comp=%b wr=%b ofm=%b tile=%0d cur=%b required all 0",
               phase, busy, rd_req, comp_en, wr_req, ofm_valid, tile_idx, cur_layer);
    end
    @(negedge clk);
    checks++;
    if (phase !== P_IDLE || ofm_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: phase=%b ofm=%b required 0000 and 0", phase, ofm_valid);
    end
    $display("reset_mid_layer: phase=%b busy=%b", phase, busy);
  endtask

  task automatic test_random_layers();
    for (int r = 0; r < 24; r++) begin
      logic [1:0] lt;
      int         n;
      lt = 2'($urandom_range(1, 3));
      n  = $urandom_range(0, 6);
      run_layer($sformatf("random_%0d", r), lt, n, -1, 1, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_ignored_idle();
    run_layer("conv_3", 2'b01, 3, 2, 0, 1'b0);
    run_layer("fully_4", 2'b11, 4, 2, 0, 1'b0);
    run_layer("zero_tiles", 2'b10, 0, 0, 1, 1'b0);
    run_layer("pause_write0", 2'b01, 3, 1, 2, 1'b0);
    run_layer("stray_pool", 2'b10, 3, 3, 0, 1'b1);
    test_reset_mid_layer();
    test_random_layers();
    run_layer("max_tiles_fully", 2'b11, 255, 0, 0, 1'b0);
    run_layer("max_tiles_conv", 2'b01, 255, 0, 1, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
